// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, default address width and
// the fetch predictor state encoding.
package y86_pkg;

  localparam int ADDR_W_DEFAULT = 64;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_pred_reg_if.sv
// Fetch-to-F-register bundle: decoded fetch fields, control and the
// registered prediction returned to PC select.
interface fetch_pred_reg_if #(
  parameter int ADDR_W = 64
);
  logic              f_valid;
  logic [3:0]        f_icode;
  logic [ADDR_W-1:0] f_valC;
  logic [ADDR_W-1:0] f_valP;
  logic              F_stall;
  logic              ras_clear;
  logic [ADDR_W-1:0] F_predPC;
  logic              F_halted;
  logic              f_ras_hit;

  modport master (
    output f_valid, f_icode, f_valC, f_valP, F_stall, ras_clear,
    input  F_predPC, F_halted, f_ras_hit
  );

  modport slave (
    input  f_valid, f_icode, f_valC, f_valP, F_stall, ras_clear,
    output F_predPC, F_halted, f_ras_hit
  );
endinterface

// File: rtl/fetch_pred_reg_ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// count saturates at DEPTH, clear empties it without touching the storage.
module ras_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [W-1:0]               data_i,
  output logic [W-1:0]               top_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] ptr_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] top_idx;

  // ptr_q points at the next free slot; the top lives just below it.
  assign top_idx = ptr_q - 1'b1;
  assign top_o   = mem_q[top_idx];
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        ptr_q <= ptr_q + 1'b1;
        if (cnt_q != CW'(DEPTH)) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else if (pop_i) begin
        ptr_q <= ptr_q - 1'b1;
        cnt_q <= cnt_q - 1'b1;
      end
      if (clear_i) begin
        cnt_q <= '0;
      end
    end
  end
endmodule

// File: rtl/fetch_pred_reg.sv
// Y86-64 fetch PC predictor and F register with halt freeze. Define
// FETCH_RAS_EN to add a return-address stack for ret prediction.
module fetch_pred_reg
  import y86_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int RAS_DEPTH = 8
) (
  input logic             clk,
  input logic             reset,
  fetch_pred_reg_if.slave fif
);
  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pred_q;
  logic [ADDR_W-1:0] pred_d;
  logic              halted_q;
  logic              accept;
  logic              is_call;
  logic              is_ret;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_nonempty;

  function automatic logic [ADDR_W-1:0] predict_pc(
    input logic [3:0]        icode,
    input logic [ADDR_W-1:0] valc,
    input logic [ADDR_W-1:0] valp,
    input logic [ADDR_W-1:0] top,
    input logic              use_top
  );
    case (icode)
      IJXX, ICALL: return valc;
      IRET:        return use_top ? top : valp;
      default:     return valp;
    endcase
  endfunction

  assign accept  = (state_q == S_RUN) && !fif.F_stall && fif.f_valid;
  assign is_call = (fif.f_icode == ICALL);
  assign is_ret  = (fif.f_icode == IRET);

`ifdef FETCH_RAS_EN
  localparam int CW = $clog2(RAS_DEPTH+1);
  logic [CW-1:0] ras_count;

  // A flush is still an update, so it is held off while stalled or halted.
  ras_stack #(
    .DEPTH(RAS_DEPTH),
    .W    (ADDR_W)
  ) u_ras (
    .clk    (clk),
    .reset  (reset),
    .push_i (accept && is_call),
    .pop_i  (accept && is_ret && ras_nonempty),
    .clear_i(fif.ras_clear && (state_q == S_RUN) && !fif.F_stall),
    .data_i (fif.f_valP),
    .top_o  (ras_top),
    .count_o(ras_count)
  );

  assign ras_nonempty = (ras_count != '0);
`else
  logic unused_ras_clear;

  assign unused_ras_clear = fif.ras_clear;
  assign ras_top          = '0;
  assign ras_nonempty     = 1'b0;
`endif

  assign pred_d        = predict_pc(fif.f_icode, fif.f_valC, fif.f_valP,
                                    ras_top, ras_nonempty);
  assign fif.f_ras_hit = fif.f_valid && is_ret && ras_nonempty;

  // F register: only an accepted instruction writes; halt latches its valP
  // and freezes everything until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RUN;
      pred_q   <= '0;
      halted_q <= 1'b0;
    end else if (accept) begin
      pred_q <= pred_d;
      if (fif.f_icode == IHALT) begin
        state_q  <= S_HALTED;
        halted_q <= 1'b1;
      end
    end
  end

  assign fif.F_predPC = pred_q;
  assign fif.F_halted = halted_q;
endmodule

// File: tb/tb_fetch_pred_reg.sv
// Directed scoreboard bench for fetch_pred_reg; RAS vectors are included
// when FETCH_RAS_EN is defined.
module tb_fetch_pred_reg;
  import y86_pkg::*;

  typedef struct {
    logic [63:0] pc;
    logic        halt;
    logic        hit;
    logic        chk_hit;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  fetch_pred_reg_if #(.ADDR_W(64)) fif ();

  fetch_pred_reg #(.ADDR_W(64), .RAS_DEPTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .fif  (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic vld, input logic [3:0] ic,
                      input logic [63:0] vc, input logic [63:0] vp,
                      input logic stl, input logic clr,
                      input logic [63:0] epc, input logic eh, input logic ehit,
                      input logic ck, input string nm);
    exp_t e;
    @(negedge clk);
    reset         = rst;
    fif.f_valid   = vld;
    fif.f_icode   = ic;
    fif.f_valC    = vc;
    fif.f_valP    = vp;
    fif.F_stall   = stl;
    fif.ras_clear = clr;
    e.pc      = epc;
    e.halt    = eh;
    e.hit     = ehit;
    e.chk_hit = ck;
    e.name    = nm;
    sb.push_back(e);
  endtask

  // Monitor: hit is sampled while the cycle's inputs are stable, the
  // registered outputs just after the following rising edge.
  initial begin
    exp_t e;
    logic hit_s;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        e     = sb.pop_front();
        hit_s = fif.f_ras_hit;
        @(posedge clk);
        #1;
        n_cmp++;
        if (fif.F_predPC !== e.pc) begin
          n_err++;
          $display("FAIL %s pc: got %h expected %h", e.name, fif.F_predPC, e.pc);
        end
        n_cmp++;
        if (fif.F_halted !== e.halt) begin
          n_err++;
          $display("FAIL %s halted: got %b expected %b", e.name, fif.F_halted, e.halt);
        end
        if (e.chk_hit) begin
          n_cmp++;
          if (hit_s !== e.hit) begin
            n_err++;
            $display("FAIL %s ras_hit: got %b expected %b", e.name, hit_s, e.hit);
          end
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    fif.f_valid = 1'b0;
    fif.f_icode = INOP;
    fif.f_valC = '0;
    fif.f_valP = '0;
    fif.F_stall = 1'b0;
    fif.ras_clear = 1'b0;

    //   rst vld icode    valC         valP   stl clr  expPC        h  hit ck
    step(1, 0, INOP,    64'h0,     64'h0,     0, 0, 64'h0,     0, 0, 1, "reset");
    step(0, 1, IIRMOVQ, 64'h0,     64'h0A,    0, 0, 64'h0A,    0, 0, 1, "seq");
    step(0, 1, IIRMOVQ, 64'h0,     64'h55,    1, 0, 64'h0A,    0, 0, 1, "stall1");
    step(0, 1, IIRMOVQ, 64'h0,     64'h56,    1, 0, 64'h0A,    0, 0, 1, "stall2");
    step(0, 1, IJXX,    64'h100,   64'h9,     0, 0, 64'h100,   0, 0, 1, "jxx");
    step(0, 1, ICALL,   64'h200,   64'h13,    0, 0, 64'h200,   0, 0, 1, "call");
`ifdef FETCH_RAS_EN
    step(0, 1, IRET,    64'h0,     64'h30,    0, 0, 64'h13,    0, 1, 1, "ret_ras");
`else
    step(0, 1, IRET,    64'h0,     64'h30,    0, 0, 64'h30,    0, 0, 1, "ret_seq");
`endif
    step(0, 1, IRET,    64'h0,     64'h40,    0, 0, 64'h40,    0, 0, 1, "ret_empty");
    step(0, 0, ICALL,   64'h777,   64'h99,    0, 0, 64'h40,    0, 0, 1, "bubble");
    step(0, 1, IRET,    64'h0,     64'h41,    0, 0, 64'h41,    0, 0, 1, "bubble_nopush");
`ifdef FETCH_RAS_EN
    for (int i = 0; i < 9; i++)
      step(0, 1, ICALL, 64'h1000 + 64'(i), 64'h10 + 64'(i), 0, 0,
           64'h1000 + 64'(i), 0, 0, 1, "ovf_call");
    for (int i = 0; i < 8; i++)
      step(0, 1, IRET, 64'h0, 64'h60 + 64'(i), 0, 0,
           64'h18 - 64'(i), 0, 1, 1, "ovf_ret");
    step(0, 1, IRET,    64'h0,     64'h70,    0, 0, 64'h70,    0, 0, 1, "ovf_empty");
    step(0, 1, ICALL,   64'h800,   64'h81,    0, 1, 64'h800,   0, 0, 1, "clr_call");
    step(0, 1, IRET,    64'h0,     64'h90,    0, 0, 64'h90,    0, 0, 1, "after_clr");
    step(0, 1, ICALL,   64'hA00,   64'hA1,    0, 0, 64'hA00,   0, 0, 1, "call2");
    step(0, 1, IRET,    64'h0,     64'hB0,    1, 0, 64'hA00,   0, 0, 0, "ret_stalled");
    step(0, 1, IRET,    64'h0,     64'hB2,    0, 0, 64'hA1,    0, 1, 1, "ret_nopop");
    step(0, 1, ICALL,   64'hC00,   64'hC1,    0, 0, 64'hC00,   0, 0, 1, "call3");
    step(0, 1, IRET,    64'h0,     64'hC8,    0, 1, 64'hC1,    0, 1, 1, "ret_clr");
    step(0, 1, IRET,    64'h0,     64'hD0,    0, 0, 64'hD0,    0, 0, 1, "ret_after_clr");
`else
    step(0, 1, IRET,    64'h0,     64'h95,    0, 1, 64'h95,    0, 0, 1, "clr_ignored");
`endif
    step(0, 1, IHALT,   64'h0,     64'h31,    0, 0, 64'h31,    1, 0, 1, "halt");
    step(0, 1, IJXX,    64'h500,   64'h3A,    0, 0, 64'h31,    1, 0, 1, "halt_jxx");
    step(0, 1, ICALL,   64'h600,   64'h37,    0, 0, 64'h31,    1, 0, 1, "halt_call");
    step(0, 1, IRET,    64'h0,     64'h38,    0, 0, 64'h31,    1, 0, 1, "halt_ret");
    step(1, 1, IJXX,    64'h700,   64'h3B,    0, 0, 64'h0,     0, 0, 1, "halt_reset");
    step(0, 1, IIRMOVQ, 64'h0,     64'h22,    0, 0, 64'h22,    0, 0, 1, "seq2");
    step(1, 1, IIRMOVQ, 64'h0,     64'h99,    1, 0, 64'h0,     0, 0, 1, "reset_stall");
    step(0, 1, IHALT,   64'h0,     64'h5,     1, 0, 64'h0,     0, 0, 1, "halt_stalled");
    step(0, 1, IIRMOVQ, 64'h0,     64'h7,     0, 0, 64'h7,     0, 0, 1, "after_halt_stl");
    step(0, 1, IJXX,    64'hFFFF_FFFF_FFFF_FFFF, 64'h8, 0, 0,
         64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, "max_addr");
    step(0, 1, INOP,    64'h0,     64'h0,     0, 0, 64'h0,     0, 0, 1, "wrap");

    @(negedge clk);
    fif.f_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_pred_reg.md
Name: fetch_pred_reg

Overview:
- Fetch-stage PC predictor and F pipeline register for the Y86-64 pipeline.
- Each cycle it takes the instruction decoded by fetch (icode, valC, valP) and computes the predicted next PC.
- The predicted PC is registered as F_predPC, which the PC-select logic consumes.
- Handles stall, halt freeze, and an optional return-address stack (RAS) for predicting ret targets.

Parameters:
- ADDR_W, 64, PC / address width.
- RAS_DEPTH, 8, RAS entry count; power of two, at least 2. Used only when the RAS feature is compiled in.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- f_valid  in  1  the fetch-stage instruction is real (not a bubble or imem error).
- f_icode  in  4  icode of the fetched instruction.
- f_valC  in  ADDR_W  constant word (jump/call destination).
- f_valP  in  ADDR_W  address of the next sequential instruction.
- F_stall  in  1  hold the F register this cycle.
- ras_clear  in  1  flush the RAS (misprediction or ret recovery from the M/W stages).
- F_predPC  out  ADDR_W  registered predicted PC.
- F_halted  out  1  a halt was fetched; F_predPC is frozen.
- f_ras_hit  out  1  combinational: the current ret prediction came from the RAS (0 when the RAS is not compiled in).

Behaviour:
- Reset (reset=1 at posedge): F_predPC=0, F_halted=0, RAS pointer=0, RAS count=0. RAS entry contents are don't-care. Reset overrides every other input, including mid-stall and while halted.
- Next-PC prediction (combinational, used only when f_valid=1):
  - icode 7 (jXX) or 8 (call) -> f_valC. All jumps are predicted taken.
  - icode 9 (ret) -> RAS top if the RAS is compiled in and count>0, otherwise f_valP.
  - icode 0 (halt) -> f_valP.
  - all other icodes -> f_valP.
- FSM states:
  - RUN: at posedge, if F_stall=0 and f_valid=1, F_predPC <= prediction. If F_stall=1 or f_valid=0, F_predPC holds.
  - RUN -> HALTED: when F_stall=0, f_valid=1 and f_icode=0. The halt's f_valP is registered on that same edge.
  - HALTED: F_predPC and the RAS are frozen and F_halted=1. Only reset leaves this state.
- Latency: one cycle from the fetched instruction to F_predPC.
- No update of any kind when F_stall=1: no register write, no push, no pop.
- Addresses wrap modulo 2^ADDR_W. There is no range checking.

Optional Feature:
- Macro: FETCH_RAS_EN.
- Defined: a circular RAS of RAS_DEPTH x ADDR_W with a pointer and a count (0..RAS_DEPTH). Updates happen only on an accepted instruction (F_stall=0, f_valid=1, state RUN).
  - call: push f_valP. On overflow (count=RAS_DEPTH) the oldest entry is overwritten; count saturates.
  - ret with count>0: pop, predict the popped value, f_ras_hit=1.
  - ret with count=0: predict f_valP, f_ras_hit=0, no state change.
  - ras_clear=1: count <= 0 at posedge, taking priority over a same-cycle push or pop. F_predPC is still updated normally that cycle.
- Undefined: no RAS storage, ret predicts f_valP, f_ras_hit is tied to 0, and ras_clear is ignored.

Decomposition:
- Shared package y86_pkg: icode constants IHALT=4'h0, INOP=4'h1, IRRMOVQ=4'h2, IIRMOVQ=4'h3, IRMMOVQ=4'h4, IMRMOVQ=4'h5, IOPQ=4'h6, IJXX=4'h7, ICALL=4'h8, IRET=4'h9, IPUSHQ=4'hA, IPOPQ=4'hB. Also the ADDR_W default.
- Sub-module ras_stack (push, pop, clear, top, count; parameters DEPTH and W). It is instantiated only under FETCH_RAS_EN.

Test Plan:
- Sequential instructions: reset, then irmovq with valP=0x0A -> F_predPC=0x0A next cycle; stall for 2 cycles -> F_predPC stays 0x0A.
- Jump and call targets: jXX with valC=0x100, valP=0x9 -> F_predPC=0x100; call with valC=0x200 -> 0x200.
- Return via RAS (RAS_EN): call with valP=0x13, then ret -> F_predPC=0x13, f_ras_hit=1; second ret on the now-empty stack with valP=0x40 -> 0x40, f_ras_hit=0.
- RAS overflow and clear: 9 calls with valP=0x10..0x18 (DEPTH=8), then 8 rets -> predictions 0x18 down to 0x11. A 9th ret falls back to its valP. ras_clear asserted in the same cycle as a call -> count=0 afterwards.
- Halt freeze: halt with valP=0x31 -> F_predPC=0x31, F_halted=1. A later jXX with valC=0x500 -> no change. Reset -> F_predPC=0, F_halted=0.
- Bubble and reset mid-stall: f_valid=0 with icode 8 -> no change and no push; reset asserted with F_stall=1 -> F_predPC=0.
